// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg
// Shared processor definitions used by the fetch unit, its bus interface and
// its testbench:
//   - instruction field widths (opcode, register select) and default sizes
//   - opcode encodings OPCODE_* and register encodings R0..R3
//   - the fetch FSM state enumeration
//   - small helpers that split an instruction word into its fields
package instr_fetch_pkg;

  localparam int OPCODE_W       = 4;
  localparam int REG_W          = 2;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int INSTR_W_DEFAULT = OPCODE_W + REG_W;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP  = 4'h0;
  localparam logic [OPCODE_W-1:0] OPCODE_LOAD = 4'h1;
  localparam logic [OPCODE_W-1:0] OPCODE_STOR = 4'h2;
  localparam logic [OPCODE_W-1:0] OPCODE_ADD  = 4'h3;
  localparam logic [OPCODE_W-1:0] OPCODE_SUB  = 4'h4;
  localparam logic [OPCODE_W-1:0] OPCODE_AND  = 4'h5;
  localparam logic [OPCODE_W-1:0] OPCODE_OR   = 4'h6;
  localparam logic [OPCODE_W-1:0] OPCODE_XOR  = 4'h7;
  localparam logic [OPCODE_W-1:0] OPCODE_SHL  = 4'h8;
  localparam logic [OPCODE_W-1:0] OPCODE_SHR  = 4'h9;
  localparam logic [OPCODE_W-1:0] OPCODE_INC  = 4'hA;
  localparam logic [OPCODE_W-1:0] OPCODE_DEC  = 4'hB;
  localparam logic [OPCODE_W-1:0] OPCODE_OUT  = 4'hF;

  localparam logic [REG_W-1:0] R0 = 2'd0;
  localparam logic [REG_W-1:0] R1 = 2'd1;
  localparam logic [REG_W-1:0] R2 = 2'd2;
  localparam logic [REG_W-1:0] R3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_PAUSE = 3'd3,
    ST_HALT  = 3'd4
  } if_state_e;

  // Instruction word layout: {opcode, reg}
  function automatic logic [OPCODE_W-1:0] instr_opcode(logic [INSTR_W_DEFAULT-1:0] w);
    return w[REG_W +: OPCODE_W];
  endfunction

  function automatic logic [REG_W-1:0] instr_reg(logic [INSTR_W_DEFAULT-1:0] w);
    return w[0 +: REG_W];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if
// Bus between the fetch unit (master) and its surroundings (slave side:
// program memory plus execute stage).
//   addr      master->slave  program memory read address (memory is combinational)
//   ins_in    slave->master  instruction word read at addr
//   ins_valid master->slave  opcode/reg_sel hold an instruction
//   ex_ready  slave->master  execute stage accepts the instruction
//   opcode    master->slave  registered opcode field
//   reg_sel   master->slave  registered register field
// Handshake: an instruction transfers on a rising edge where ins_valid and
// ex_ready are both high. Once ins_valid is high, opcode/reg_sel stay
// constant until that edge; ex_ready may toggle freely.
interface instr_fetch_if #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 6
);
  import instr_fetch_pkg::*;

  logic [ADDR_W-1:0]   addr;
  logic [INSTR_W-1:0]  ins_in;
  logic                ins_valid;
  logic                ex_ready;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    reg_sel;

  modport master (
    output addr, ins_valid, opcode, reg_sel,
    input  ins_in, ex_ready
  );

  modport slave (
    input  addr, ins_valid, opcode, reg_sel,
    output ins_in, ex_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
// Sequencer that walks a program from address 0 to last_addr, latching each
// word into an instruction register and offering it to the execute stage.
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   start           pulse: run from address 0 (accepted in IDLE and HALT)
//   step_mode       1 = pause after every issued instruction
//   step            pulse: leave PAUSE and fetch the next instruction
//   stop            abort to HALT from FETCH/ISSUE/PAUSE
//   last_addr       address of the final program instruction
//   bus             instr_fetch_if master (addr, ins_in, ins_valid, ex_ready,
//                   opcode, reg_sel)
//   busy            high in FETCH, ISSUE, PAUSE
//   halted          high in HALT
//   dbg_state_o     current FSM state
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  input  logic              stop,
  input  logic [ADDR_W-1:0] last_addr,
  instr_fetch_if.master     bus,
  output logic              busy,
  output logic              halted,
  output if_state_e         dbg_state_o
);

  if_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (stop) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else begin
          ir_d    = bus.ins_in;
          valid_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // stop wins over a handshake on the same edge
        if (stop) begin
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (valid_q && bus.ex_ready) begin
          valid_d = 1'b0;
          if (pc_q == last_addr) begin
            // last instruction: pc is left pointing at it, never wraps
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = step_mode ? ST_PAUSE : ST_FETCH;
          end
        end
      end
      ST_PAUSE: begin
        valid_d = 1'b0;
        if (stop) begin
          state_d = ST_HALT;
        end else if (step) begin
          state_d = ST_FETCH;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.addr      = pc_q;
  assign bus.ins_valid = valid_q;
  assign bus.opcode    = ir_q[REG_W +: OPCODE_W];
  assign bus.reg_sel   = ir_q[0 +: REG_W];
  assign busy          = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                         (state_q == ST_PAUSE);
  assign halted        = (state_q == ST_HALT);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch
// Directed bench for instr_fetch: a 32-word combinational program memory,
// a handshake monitor feeding a scoreboard, and a linear sequence of steps.
// Inputs change 1 time unit after a rising edge; checks are made there too.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int AW = 5;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, step_mode, step, stop;
  logic [AW-1:0] last_addr;
  logic          busy, halted;
  if_state_e     dbg_state;

  logic [IW-1:0] mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  // scoreboard entries are {addr, instruction word}
  logic [AW+IW-1:0] exp_q[$];
  logic [AW+IW-1:0] got_q[$];

  instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  instr_fetch #(.ADDR_W(AW), .INSTR_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step_mode   (step_mode),
    .step        (step),
    .stop        (stop),
    .last_addr   (last_addr),
    .bus         (bus),
    .busy        (busy),
    .halted      (halted),
    .dbg_state_o (dbg_state)
  );

  assign bus.ins_in = mem[bus.addr];

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // handshake monitor: the transfer happens on the next rising edge
  always @(negedge clk) begin
    if (rst_n && !stop && bus.ins_valid && bus.ex_ready)
      got_q.push_back({bus.addr, bus.opcode, bus.reg_sel});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input if_state_e target, input int budget, input string tag);
    int n = 0;
    while (dbg_state !== target && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(dbg_state), 32'(target));
  endtask

  task automatic push_exp(input int lo, input int hi);
    for (int a = lo; a <= hi; a++)
      exp_q.push_back({AW'(a), mem[a]});
  endtask

  task automatic sb_check(input string tag);
    logic [AW+IW-1:0] e, g;
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_item"}, 32'(g), 32'(e));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = IW'(i * 5 + 9);
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; stop = 1'b0;
    last_addr = 5'd16;
    bus.ex_ready = 1'b1;

    // reset state
    tick(2);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    chk("rst_addr",   32'(bus.addr), 32'd0);
    chk("rst_valid",  32'(bus.ins_valid), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_ir",     32'({bus.opcode, bus.reg_sel}), 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_hold", 32'(dbg_state), 32'(ST_IDLE));

    // 17-instruction run, ex_ready high: 2 cycles per instruction
    push_exp(0, 16);
    pulse_start();
    chk("run_fetch0", 32'(dbg_state), 32'(ST_FETCH));
    tick(1);
    chk("run_issue0", 32'({bus.opcode, bus.reg_sel}), 32'(mem[0]));
    tick(32);
    chk("run_issue16_state", 32'(dbg_state), 32'(ST_ISSUE));
    chk("run_issue16_addr",  32'(bus.addr), 32'd16);
    chk("run_not_halted",    32'(halted), 32'd0);
    tick(1);
    chk("run_halted",   32'(halted), 32'd1);
    chk("run_busy",     32'(busy), 32'd0);
    chk("run_addr",     32'(bus.addr), 32'd16);
    chk("run_valid",    32'(bus.ins_valid), 32'd0);
    sb_check("run17");

    // backpressure: ex_ready low for 5 cycles while issuing address 3
    push_exp(0, 16);
    pulse_start();
    tick(6);
    bus.ex_ready = 1'b0;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_state", 32'(dbg_state), 32'(ST_ISSUE));
      chk("bp_addr",  32'(bus.addr), 32'd3);
      chk("bp_valid", 32'(bus.ins_valid), 32'd1);
      chk("bp_ir",    32'({bus.opcode, bus.reg_sel}), 32'(mem[3]));
      tick(1);
    end
    bus.ex_ready = 1'b1;
    wait_state(ST_HALT, 100, "bp_halt");
    sb_check("bp");

    // single-step mode
    step_mode = 1'b1;
    push_exp(0, 3);
    pulse_start();
    tick(2);
    chk("step_pause0", 32'(dbg_state), 32'(ST_PAUSE));
    chk("step_addr0",  32'(bus.addr), 32'd1);
    chk("step_valid0", 32'(bus.ins_valid), 32'd0);
    tick(3);
    chk("step_hold", 32'(dbg_state), 32'(ST_PAUSE));
    chk("step_hold_count", 32'(got_q.size()), 32'd1);
    for (int s = 1; s <= 3; s++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      chk("step_fetch", 32'(bus.addr), 32'(s));
      tick(2);
      chk("step_pause", 32'(dbg_state), 32'(ST_PAUSE));
      chk("step_addr",  32'(bus.addr), 32'(s + 1));
    end
    sb_check("step");
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("step_stop_state", 32'(dbg_state), 32'(ST_HALT));
    chk("step_stop_addr",  32'(bus.addr), 32'd4);
    step_mode = 1'b0;

    // stop concurrent with a handshake at address 7
    push_exp(0, 6);
    pulse_start();
    tick(15);
    chk("stop_pre_addr", 32'(bus.addr), 32'd7);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_state", 32'(dbg_state), 32'(ST_HALT));
    chk("stop_addr",  32'(bus.addr), 32'd7);
    chk("stop_valid", 32'(bus.ins_valid), 32'd0);
    sb_check("stop");
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
    chk("stop_in_halt", 32'(dbg_state), 32'(ST_HALT));
    push_exp(0, 4);
    pulse_start();
    chk("restart_addr", 32'(bus.addr), 32'd0);
    tick(1);
    chk("restart_ir", 32'({bus.opcode, bus.reg_sel}), 32'(mem[0]));

    // asynchronous reset in the middle of issuing address 5
    tick(10);
    chk("mid_addr",  32'(bus.addr), 32'd5);
    chk("mid_valid", 32'(bus.ins_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ins_valid), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("arst_addr",  32'(bus.addr), 32'd0);
    chk("arst_ir",    32'({bus.opcode, bus.reg_sel}), 32'd0);
    sb_check("arst");
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    pulse_start();
    chk("post_rst_addr", 32'(bus.addr), 32'd0);
    tick(1);
    chk("post_rst_ir", 32'({bus.opcode, bus.reg_sel}), 32'(mem[0]));
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    exp_q.delete();
    got_q.delete();

    // full address space: halts at the top, no wrap
    last_addr = 5'd31;
    push_exp(0, 31);
    pulse_start();
    wait_state(ST_HALT, 100, "top_halt");
    chk("top_addr", 32'(bus.addr), 32'd31);
    sb_check("top");
    tick(3);
    chk("top_stay",  32'(dbg_state), 32'(ST_HALT));
    chk("top_addr2", 32'(bus.addr), 32'd31);
    chk("top_nowrap", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
